// File: rtl/cnn_img_loader_pkg.sv
// Shared constants and state encoding for the CNN image loader and the CNN top.
package cnn_img_loader_pkg;

    localparam int IMG_SIZE = 64;
    localparam int DATA_W   = 32;
    localparam int OUT_W    = 32;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_frame_buf.sv
// Frame store: IMG_SIZE registered pixel slots, one write port, whole frame on a flat bus.
module cnn_frame_buf
    import cnn_img_loader_pkg::*;
#(
    parameter int IMG_SIZE = cnn_img_loader_pkg::IMG_SIZE,
    parameter int DATA_W   = cnn_img_loader_pkg::DATA_W,
    parameter int IDX_W    = idx_width(IMG_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [IMG_SIZE*DATA_W-1:0] img_bus
);

    for (genvar k = 0; k < IMG_SIZE; k++) begin : g_slot
        logic [DATA_W-1:0] slot_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                slot_q <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(k))) begin
                slot_q <= wr_data;
            end
        end

        assign img_bus[k*DATA_W +: DATA_W] = slot_q;
    end

endmodule

// File: rtl/cnn_img_loader.sv
// Collects one frame of pixels, holds it steady for the CNN core while it runs,
// and latches the core's prediction and a completed-frame count.
//
// state | meaning
// FILL  | accepting pixels into the frame store
// RUN   | frame complete, core enabled, waiting for core_done
// DRAIN | over-long frame, discarding pixels up to pix_last
module cnn_img_loader
    import cnn_img_loader_pkg::*;
#(
    parameter int IMG_SIZE = cnn_img_loader_pkg::IMG_SIZE,
    parameter int DATA_W   = cnn_img_loader_pkg::DATA_W,
    parameter int OUT_W    = cnn_img_loader_pkg::OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid,
    input  logic [DATA_W-1:0]          pix_data,
    input  logic                       pix_last,
    output logic                       pix_ready,
    output logic [IMG_SIZE*DATA_W-1:0] img_bus,
    output logic                       core_enable,
    input  logic [OUT_W-1:0]           core_value,
    input  logic                       core_done,
    output logic [OUT_W-1:0]           result,
    output logic                       result_valid,
    output logic                       frame_err,
    output logic [15:0]                frame_cnt
);

    localparam int               IDX_W    = idx_width(IMG_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_SIZE - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] wr_idx;
    logic             buf_we;
    logic             idx_inc;
    logic             idx_clr;
    logic             err_set;
    logic             capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pix_ready   = 1'b0;
        core_enable = 1'b0;
        buf_we      = 1'b0;
        idx_inc     = 1'b0;
        idx_clr     = 1'b0;
        err_set     = 1'b0;
        capture     = 1'b0;

        case (state)
            FILL: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    buf_we = 1'b1;
                    if (wr_idx == LAST_IDX) begin
                        idx_clr = 1'b1;
                        if (pix_last) begin
                            state_nxt = RUN;
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = DRAIN;
                        end
                    end else if (pix_last) begin
                        // short frame: restart without running the core
                        err_set = 1'b1;
                        idx_clr = 1'b1;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end

            DRAIN: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_last) begin
                    state_nxt = FILL;
                end
            end

            RUN: begin
                core_enable = 1'b1;
                if (core_done) begin
                    capture   = 1'b1;
                    state_nxt = FILL;
                end
            end

            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            result_valid <= capture;
            frame_err    <= err_set;
            if (idx_clr) begin
                wr_idx <= '0;
            end else if (idx_inc) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (capture) begin
                result    <= core_value;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    cnn_frame_buf #(
        .IMG_SIZE (IMG_SIZE),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we),
        .wr_idx  (wr_idx),
        .wr_data (pix_data),
        .img_bus (img_bus)
    );

endmodule

// File: tb/tb_cnn_img_loader.sv
// Scoreboard bench for cnn_img_loader: stimulus pushes expected events, a negedge monitor pops them.
module tb_cnn_img_loader;

    localparam int IMG   = 64;
    localparam int DW    = 32;
    localparam int OW    = 32;
    localparam int BUS_W = IMG * DW;

    localparam int K_FRAME = 0;
    localparam int K_RES   = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int               kind;
        logic [OW-1:0]    val;
        logic [15:0]      cnt;
        logic [BUS_W-1:0] bus;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             pix_valid;
    logic [DW-1:0]    pix_data;
    logic             pix_last;
    logic             pix_ready;
    logic [BUS_W-1:0] img_bus;
    logic             core_enable;
    logic [OW-1:0]    core_value;
    logic             core_done;
    logic [OW-1:0]    result;
    logic             result_valid;
    logic             frame_err;
    logic [15:0]      frame_cnt;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_ce = 1'b0;

    cnn_img_loader #(
        .IMG_SIZE (IMG),
        .DATA_W   (DW),
        .OUT_W    (OW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_last     (pix_last),
        .pix_ready    (pix_ready),
        .img_bus      (img_bus),
        .core_enable  (core_enable),
        .core_value   (core_value),
        .core_done    (core_done),
        .result       (result),
        .result_valid (result_valid),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bus(input string nm, input logic [BUS_W-1:0] exp);
        int bad_k;
        bad_k = -1;
        for (int k = IMG - 1; k >= 0; k--) begin
            if (img_bus[k*DW +: DW] !== exp[k*DW +: DW]) bad_k = k;
        end
        n_cmp++;
        if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL %s: word %0d got %0h want %0h (t=%0t)", nm, bad_k,
                     img_bus[bad_k*DW +: DW], exp[bad_k*DW +: DW], $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] bus_const(input logic [DW-1:0] v);
        logic [BUS_W-1:0] b;
        for (int k = 0; k < IMG; k++) b[k*DW +: DW] = v;
        return b;
    endfunction

    function automatic logic [BUS_W-1:0] bus_idx();
        logic [BUS_W-1:0] b;
        for (int k = 0; k < IMG; k++) b[k*DW +: DW] = DW'(k);
        return b;
    endfunction

    task automatic push(input int kind, input logic [OW-1:0] val, input logic [15:0] cnt,
                        input logic [BUS_W-1:0] bus);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cnt  = cnt;
        e.bus  = bus;
        sb.push_back(e);
    endtask

    task automatic pop_check(input int kind, input string nm);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event, got kind %0d want none (t=%0t)", nm, kind, $time);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind) begin
            n_bad++;
            $display("FAIL %s: event order got kind %0d want kind %0d (t=%0t)", nm, kind, e.kind, $time);
            return;
        end
        if (kind == K_RES) begin
            chk("mon_result", 64'(result), 64'(e.val));
            chk("mon_frame_cnt", 64'(frame_cnt), 64'(e.cnt));
        end else if (kind == K_FRAME) begin
            chk_bus("mon_img_bus", e.bus);
            chk("mon_ready_in_run", 64'(pix_ready), 64'(0));
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) pop_check(K_RES, "result_valid");
        if (frame_err) pop_check(K_ERR, "frame_err");
        if (core_enable && !prev_ce) pop_check(K_FRAME, "core_enable_rise");
        prev_ce <= core_enable;
    end

    task automatic send_pix(input logic [DW-1:0] d, input logic l);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] v);
        for (int k = 0; k < IMG; k++) begin
            send_pix(v, k == IMG - 1);
            if (k == IMG - 2) chk("ce_low_before_last", 64'(core_enable), 64'(0));
        end
        chk("ce_rise_latency", 64'(core_enable), 64'(1));
        chk("ready_low_run", 64'(pix_ready), 64'(0));
    endtask

    task automatic run_core(input logic [OW-1:0] v, input logic [15:0] cnt,
                            input logic [BUS_W-1:0] bus);
        repeat (10) @(posedge clk);
        #1;
        chk_bus("bus_stable_run", bus);
        chk("ce_held_run", 64'(core_enable), 64'(1));
        push(K_RES, v, cnt, '0);
        core_value = v;
        core_done  = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        chk("ce_drop_done", 64'(core_enable), 64'(0));
        chk("ready_after_done", 64'(pix_ready), 64'(1));
        chk("result_latched", 64'(result), 64'(v));
        @(posedge clk);
        #1;
        chk("result_valid_one_pulse", 64'(result_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUS_W-1:0] exp_bus;
        rst        = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        pix_last   = 1'b0;
        core_value = '0;
        core_done  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_enable", 64'(core_enable), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("rst_result_valid", 64'(result_valid), 64'(0));
        chk("rst_frame_err", 64'(frame_err), 64'(0));
        chk_bus("rst_img_bus", '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(pix_ready), 64'(1));

        // full frame of ones, core answers 42
        push(K_FRAME, '0, '0, bus_const(32'd1));
        send_frame(32'd1);
        run_core(32'd42, 16'd1, bus_const(32'd1));

        // core_done outside RUN is ignored
        core_value = 32'd777;
        core_done  = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        chk("done_ignored_result", 64'(result), 64'(42));
        chk("done_ignored_cnt", 64'(frame_cnt), 64'(1));

        // short frame: last on pixel 10
        push(K_ERR, '0, '0, '0);
        for (int k = 0; k <= 10; k++) send_pix(32'd5, k == 10);
        chk("short_err_pulse", 64'(frame_err), 64'(1));
        chk("short_no_ce", 64'(core_enable), 64'(0));
        chk("short_ready", 64'(pix_ready), 64'(1));

        push(K_FRAME, '0, '0, bus_const(32'd7));
        send_frame(32'd7);
        run_core(32'h1234, 16'd2, bus_const(32'd7));

        // short frame keeps untouched slots
        push(K_ERR, '0, '0, '0);
        for (int k = 0; k <= 3; k++) send_pix(32'd9, k == 3);
        exp_bus = bus_const(32'd7);
        for (int k = 0; k <= 3; k++) exp_bus[k*DW +: DW] = 32'd9;
        chk_bus("short_keeps_slots", exp_bus);

        // long frame: 70 pixels, last on 69
        for (int k = 0; k < 70; k++) begin
            if (k == IMG - 1) push(K_ERR, '0, '0, '0);
            send_pix(32'd3, k == 69);
            if (k == IMG - 1) begin
                chk("long_err_at_63", 64'(frame_err), 64'(1));
                chk("long_drain_ready", 64'(pix_ready), 64'(1));
            end
        end
        chk("long_no_ce", 64'(core_enable), 64'(0));
        chk("long_back_fill_ready", 64'(pix_ready), 64'(1));

        // index pattern with random valid gaps
        push(K_FRAME, '0, '0, bus_idx());
        for (int k = 0; k < IMG; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_pix(DW'(k), k == IMG - 1);
        end
        chk("idx_ce_rise", 64'(core_enable), 64'(1));
        run_core(32'd99, 16'd3, bus_idx());

        // reset in the middle of RUN
        push(K_FRAME, '0, '0, bus_const(32'd1));
        send_frame(32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_ce_drop", 64'(core_enable), 64'(0));
        chk("rst_run_frame_cnt", 64'(frame_cnt), 64'(0));
        chk_bus("rst_run_bus_clear", '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst_run", 64'(pix_ready), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnn_img_loader.md
CNN_IMG_LOADER -- requirements
Module: cnn_img_loader

Interface
REQ-001 SHALL have parameter IMG_SIZE, default 64: pixels per frame.
REQ-002 SHALL have parameter DATA_W, default 32: bits per pixel word.
REQ-003 SHALL have parameter OUT_W, default 32: width of the CNN result.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port pix_valid, input, 1: upstream pixel present.
REQ-007 SHALL have port pix_data, input, DATA_W: pixel word.
REQ-008 SHALL have port pix_last, input, 1: marks the final pixel of a frame.
REQ-009 SHALL have port pix_ready, output, 1: loader accepts a pixel this cycle.
REQ-010 SHALL have port img_bus, output, IMG_SIZE*DATA_W: frame to the core; pixel k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port core_enable, output, 1: level that starts and holds the core.
REQ-012 SHALL have port core_value, input, OUT_W: core prediction.
REQ-013 SHALL have port core_done, input, 1: core result valid.
REQ-014 SHALL have port result, output, OUT_W: latched prediction.
REQ-015 SHALL have port result_valid, output, 1: one-cycle pulse when result updates.
REQ-016 SHALL have port frame_err, output, 1: one-cycle pulse on malformed frame.
REQ-017 SHALL have port frame_cnt, output, 16: count of frames completed by the core.

Function
REQ-018 SHALL implement the FSM states FILL, RUN and DRAIN.
REQ-019 In FILL, pix_ready SHALL be 1; a pixel transfers when pix_valid && pix_ready and is written to slot wr_idx; wr_idx then increments.
REQ-020 If the transfer at wr_idx==IMG_SIZE-1 carries pix_last=1, the FSM SHALL go FILL->RUN and wr_idx SHALL clear to 0.
REQ-021 If pix_last=1 arrives with wr_idx<IMG_SIZE-1 (short frame), the loader SHALL pulse frame_err, clear wr_idx to 0, stay in FILL and not assert core_enable.
REQ-022 If the transfer at wr_idx==IMG_SIZE-1 carries pix_last=0 (long frame), the loader SHALL pulse frame_err and enter DRAIN.
REQ-023 In DRAIN, pix_ready SHALL be 1 and accepted pixels SHALL be discarded; the accept with pix_last=1 SHALL return the FSM to FILL with wr_idx=0.
REQ-024 In RUN, pix_ready SHALL be 0, core_enable SHALL be 1 and img_bus SHALL remain stable.
REQ-025 In RUN, core_done sampled 1 at a rising edge SHALL capture core_value into result, pulse result_valid the following cycle, increment frame_cnt (wrapping 0xFFFF->0), drop core_enable and return to FILL.
REQ-026 The first pixel of the next frame SHALL be accepted no earlier than the cycle after core_enable falls.
REQ-027 core_enable SHALL first rise on the cycle after the last pixel is accepted, giving 1-cycle latency.
REQ-028 core_done while not in RUN SHALL be ignored.
REQ-029 Slots not written by a short frame SHALL keep their previous contents.

Reset
REQ-030 With rst low, the FSM SHALL be in FILL and wr_idx, img_bus, result, frame_cnt, core_enable, result_valid and frame_err SHALL be 0.
REQ-031 pix_ready SHALL be 1 one cycle after rst deasserts.
REQ-032 Reset during RUN SHALL drop core_enable immediately (asynchronously) and discard the frame.

Structure
REQ-033 A shared package SHALL hold IMG_SIZE, DATA_W, OUT_W and the state encoding, and it SHALL be shared with cnn_top.
REQ-034 The frame store SHALL be a sub-module, cnn_frame_buf: IMG_SIZE x DATA_W registers with a write port and a flat read bus.
REQ-035 wr_idx SHALL be $clog2(IMG_SIZE) bits wide.

Verification
REQ-036 The bench SHALL cover: 64 pixels all 1, pix_last on pixel 63 -> core_enable rises the next cycle; all img_bus words =1; pix_ready=0.
REQ-037 The bench SHALL cover: model core asserts done with value=42 ten cycles later -> result=42, one result_valid pulse, frame_cnt=1, pix_ready=1.
REQ-038 The bench SHALL cover: pix_last on pixel 10 -> frame_err pulse, no core_enable, next full frame of value 7 -> img_bus words all 7.
REQ-039 The bench SHALL cover: 70 pixels, last on pixel 69 -> frame_err at pixel 63, pixels 64-69 dropped, back in FILL, core_enable never asserted.
REQ-040 The bench SHALL cover: rst low mid-RUN -> core_enable=0 asynchronously, frame_cnt=0, pix_ready=1 after release.
REQ-041 The bench SHALL cover: pix_valid toggling randomly over 64 pixels of values 0..63 -> img_bus word k = k.
